// File: rtl/mem_stage_ctrl.sv
// Memory stage behind the X/M latch: passes ALU/jal results through to the M/W bundle and
// runs a req/ack data-memory access for loads and stores, stalling X/M while it is outstanding.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int LW_BIT  = 0,
  parameter int SW_BIT  = 1,
  parameter int RW_BIT  = 2,
  parameter int JAL_BIT = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [13:0]       in_ctrl_signals,
  input  logic [31:0]       in_ALU_result,
  input  logic [31:0]       in_data_reg,
  input  logic [31:0]       in_PC_plus1,
  input  logic [4:0]        in_rd,
  output logic              stall_xm,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mw_valid,
  output logic              mw_reg_write,
  output logic [4:0]        mw_rd,
  output logic [31:0]       mw_data,
  output logic              mem_err,
  output logic              dbg_state
);

  // Handshake: dmem_req rises with addr/wdata/we already valid and all four stay frozen until
  // the cycle dmem_ack is seen high (or the timeout fires); ack is only honoured while req=1.

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        hold_rd_q, hold_rd_d;
  logic              hold_rw_q, hold_rw_d;
  logic              hold_lw_q, hold_lw_d;
  logic              mw_valid_q, mw_valid_d;
  logic              mw_reg_write_q, mw_reg_write_d;
  logic [4:0]        mw_rd_q, mw_rd_d;
  logic [31:0]       mw_data_q, mw_data_d;
  logic              err_q, err_d;

  logic        op_lw, op_sw, op_rw, op_jal, rd_nz;
  logic [31:0] addr_ext;
  logic        unused_ctrl;

  assign op_lw       = in_ctrl_signals[LW_BIT];
  assign op_sw       = in_ctrl_signals[SW_BIT];
  assign op_rw       = in_ctrl_signals[RW_BIT];
  assign op_jal      = in_ctrl_signals[JAL_BIT];
  assign rd_nz       = (in_rd != 5'd0);
  assign addr_ext    = 32'(addr_q);
  assign unused_ctrl = ^in_ctrl_signals;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      hold_rd_q      <= '0;
      hold_rw_q      <= 1'b0;
      hold_lw_q      <= 1'b0;
      mw_valid_q     <= 1'b0;
      mw_reg_write_q <= 1'b0;
      mw_rd_q        <= '0;
      mw_data_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      hold_rd_q      <= hold_rd_d;
      hold_rw_q      <= hold_rw_d;
      hold_lw_q      <= hold_lw_d;
      mw_valid_q     <= mw_valid_d;
      mw_reg_write_q <= mw_reg_write_d;
      mw_rd_q        <= mw_rd_d;
      mw_data_q      <= mw_data_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    hold_rd_d      = hold_rd_q;
    hold_rw_d      = hold_rw_q;
    hold_lw_d      = hold_lw_q;
    mw_valid_d     = 1'b0;
    mw_reg_write_d = 1'b0;
    mw_rd_d        = mw_rd_q;
    mw_data_d      = mw_data_q;
    err_d          = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op_lw || op_sw) begin
            // Load wins when both bits are set, so dmem_we is simply "not a load".
            state_d   = ACCESS;
            cnt_d     = '0;
            req_d     = 1'b1;
            we_d      = ~op_lw;
            addr_d    = in_ALU_result[ADDR_W-1:0];
            wdata_d   = in_data_reg;
            hold_rd_d = in_rd;
            hold_rw_d = op_rw & rd_nz;
            hold_lw_d = op_lw;
          end else begin
            mw_valid_d     = 1'b1;
            mw_rd_d        = in_rd;
            mw_data_d      = op_jal ? in_PC_plus1 : in_ALU_result;
            mw_reg_write_d = (op_rw | op_jal) & rd_nz;
          end
        end
      end
      ACCESS: begin
        if (req_q && dmem_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          mw_valid_d = 1'b1;
          mw_rd_d    = hold_rd_q;
          if (hold_lw_q) begin
            mw_data_d      = dmem_rdata;
            mw_reg_write_d = hold_rw_q;
          end else begin
            mw_data_d      = addr_ext;
            mw_reg_write_d = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Give up: retire the instruction without a register write and flag the error.
          state_d    = IDLE;
          req_d      = 1'b0;
          mw_valid_d = 1'b1;
          mw_rd_d    = hold_rd_q;
          mw_data_d  = addr_ext;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_xm     = (state_q == ACCESS);
  assign dbg_state    = state_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign mw_valid     = mw_valid_q;
  assign mw_reg_write = mw_reg_write_q;
  assign mw_rd        = mw_rd_q;
  assign mw_data      = mw_data_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: an X/M driver, a data-memory responder with per-access ack delays,
// and a writeback scoreboard whose entries come from the instruction rules and ack delays.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] in_ctrl_signals = '0;
  logic [31:0] in_ALU_result = '0;
  logic [31:0] in_data_reg = '0;
  logic [31:0] in_PC_plus1 = '0;
  logic [4:0]  in_rd = '0;
  logic        stall_xm, dmem_req, dmem_we;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mw_valid, mw_reg_write, mem_err, dbg_state;
  logic [4:0]  mw_rd;
  logic [31:0] mw_data;

  mem_stage_ctrl #(.ADDR_W(12), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ctrl_signals(in_ctrl_signals),
    .in_ALU_result(in_ALU_result), .in_data_reg(in_data_reg), .in_PC_plus1(in_PC_plus1),
    .in_rd(in_rd), .stall_xm(stall_xm), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mw_valid(mw_valid), .mw_reg_write(mw_reg_write),
    .mw_rd(mw_rd), .mw_data(mw_data), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] due;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk_rd;
    logic        chk_data;
    logic        tmo;
  } wb_t;

  typedef struct packed {
    logic [31:0] delay;
    logic [31:0] rdata;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
  } mem_t;

  wb_t  exp_q[$];
  mem_t mem_q[$];
  int   checks = 0;
  int   errors = 0;
  int   neg_cnt = 0;
  int   req_cyc = 0;
  int   pending_stall = 0;
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Writeback monitor: pops one expectation per mw_valid pulse, at the exact cycle it is due.
  wb_t e;
  always @(negedge clock) begin
    neg_cnt++;
    if (!reset) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      if (mw_valid) begin
        if (exp_q.size() == 0) begin
          check("mw_valid_spurious", 32'(mw_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_cycle", 32'(neg_cnt), e.due);
          if (e.tmo) exp_err = 1'b1;
          check("mw_reg_write", 32'(mw_reg_write), 32'(e.rw));
          if (e.chk_rd) check("mw_rd", 32'(mw_rd), 32'(e.rd));
          if (e.chk_data) check("mw_data", mw_data, e.data);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0].due) <= neg_cnt) begin
        check("mw_valid_missing", 32'(mw_valid), 32'd1);
        void'(exp_q.pop_front());
      end
      check("mem_err", 32'(mem_err), 32'(exp_err));
    end
  end

  // Data-memory responder: acks on the delay-th request cycle; random acks while idle.
  mem_t m;
  always @(negedge clock) begin
    if (!reset) begin
      mem_q.delete();
      req_cyc  = 0;
      dmem_ack = 1'b0;
    end else if (dmem_req) begin
      req_cyc++;
      if (mem_q.size() == 0) begin
        check("dmem_req_unexpected", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b1;
      end else begin
        m = mem_q[0];
        check("dmem_addr", 32'(dmem_addr), 32'(m.addr));
        check("dmem_we", 32'(dmem_we), 32'(m.we));
        if (m.we) check("dmem_wdata", dmem_wdata, m.wdata);
        if (req_cyc == int'(m.delay)) begin
          dmem_ack   = 1'b1;
          dmem_rdata = m.rdata;
          void'(mem_q.pop_front());
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
          if (req_cyc >= TIMEOUT) void'(mem_q.pop_front());
        end
      end
    end else begin
      req_cyc    = 0;
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
    end
  end

  // ---------------- driver ----------------
  // Presents one X/M slot (v=0 is a bubble), waits until the stage takes it (stall_xm low at
  // an edge), checks the stall length left by the previous memory op, and books the result.
  task automatic issue(input logic v, input logic [13:0] ctrl, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] pc1, input logic [4:0] rd,
                       input int delay, input logic [31:0] rdata);
    logic s;
    logic taken;
    int   stalls;
    int   k;
    int   lat;
    logic is_lw, is_mem;
    wb_t  w;
    mem_t mm;
    in_valid        = v;
    in_ctrl_signals = ctrl;
    in_ALU_result   = alu;
    in_data_reg     = sd;
    in_PC_plus1     = pc1;
    in_rd           = rd;
    taken  = 1'b0;
    stalls = 0;
    for (int i = 0; i < 300 && !taken; i++) begin
      @(negedge clock);
      s = stall_xm;
      if (s) stalls++;
      @(posedge clock);
      if (!s) taken = 1'b1;
    end
    k = neg_cnt;
    check("consumed", 32'(taken), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(pending_stall));
    is_lw  = ctrl[0];
    is_mem = ctrl[0] | ctrl[1];
    lat    = (delay <= TIMEOUT) ? delay : TIMEOUT;
    pending_stall = (v && is_mem) ? lat : 0;
    if (v) begin
      w.rd       = rd;
      w.chk_rd   = 1'b1;
      w.chk_data = 1'b1;
      w.tmo      = 1'b0;
      if (!is_mem) begin
        w.due  = 32'(k + 1);
        w.rw   = (ctrl[2] | ctrl[3]) && (rd != 5'd0);
        w.data = ctrl[3] ? pc1 : alu;
      end else begin
        w.due = 32'(k + lat + 1);
        if (delay > TIMEOUT) begin
          w.tmo      = 1'b1;
          w.rw       = 1'b0;
          w.data     = '0;
          w.chk_rd   = 1'b0;
          w.chk_data = 1'b0;
        end else if (is_lw) begin
          w.rw   = ctrl[2] && (rd != 5'd0);
          w.data = rdata;
        end else begin
          w.rw   = 1'b0;
          w.data = {20'd0, alu[11:0]};
        end
        mm.delay = 32'(delay);
        mm.rdata = rdata;
        mm.addr  = alu[11:0];
        mm.wdata = sd;
        mm.we    = !is_lw;
        mem_q.push_back(mm);
      end
      exp_q.push_back(w);
    end
    #1;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, '0, '0, '0, '0, '0, 0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int dly;
    logic [13:0] c;
    logic [4:0]  r;

    #1;
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_stall_xm", 32'(stall_xm), 32'd0);
    check("rst_mw_valid", 32'(mw_valid), 32'd0);
    check("rst_mw_data", mw_data, 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // add rd=5 -> writeback one cycle later
    issue(1'b1, 14'h0004, 32'h0000_1234, 32'h0, 32'h100, 5'd5, 0, '0);
    // lw rd=7 addr 0x040, ack on 3rd request cycle
    issue(1'b1, 14'h0005, 32'h0000_0040, 32'h0, 32'h101, 5'd7, 3, 32'hDEAD_BEEF);
    // sw acked immediately, followed directly by an add
    issue(1'b1, 14'h0002, 32'h0000_0010, 32'hCAFE_0000, 32'h102, 5'd0, 1, '0);
    issue(1'b1, 14'h0004, 32'h0000_0077, 32'h0, 32'h103, 5'd9, 0, '0);
    // lw with both lw and sw bits set behaves as a load
    issue(1'b1, 14'h0007, 32'h0000_0ABC, 32'h1111_2222, 32'h104, 5'd12, 2, 32'h0BAD_F00D);
    // ack on the last allowed cycle completes normally
    issue(1'b1, 14'h0005, 32'h0000_0123, 32'h0, 32'h105, 5'd4, TIMEOUT, 32'h55AA_55AA);
    bubbles(2);
    // jal rd=31 and add/lw to rd=0
    issue(1'b1, 14'h0008, 32'hFFFF_0000, 32'h0, 32'h0000_0021, 5'd31, 0, '0);
    issue(1'b1, 14'h0004, 32'h0000_0042, 32'h0, 32'h106, 5'd0, 0, '0);
    issue(1'b1, 14'h0005, 32'h0000_0200, 32'h0, 32'h107, 5'd0, 1, 32'h1234_5678);
    // no ack at all -> timeout, sticky error
    issue(1'b1, 14'h0005, 32'h0000_0300, 32'h0, 32'h108, 5'd3, TIMEOUT + 10, 32'h0);
    bubbles(3);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5);
      r    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'(($urandom));
      dly  = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 4)
                                         : $urandom_range(1, TIMEOUT);
      c    = 14'($urandom) & 14'h3FFC;
      case (kind)
        0:       issue(1'b0, c, $urandom, $urandom, $urandom, r, 0, '0);
        1, 2:    issue(1'b1, c, $urandom, $urandom, $urandom, r, 0, '0);
        3:       issue(1'b1, c | 14'h0001 | 14'($urandom_range(0, 1) << 1),
                       32'($urandom_range(0, 4095)), $urandom, $urandom, r, dly, $urandom);
        default: issue(1'b1, c | 14'h0002, 32'($urandom_range(0, 4095)), $urandom, $urandom,
                       r, dly, $urandom);
      endcase
    end
    bubbles(3);

    // reset in the middle of an access clears everything at once
    issue(1'b1, 14'h0005, 32'h0000_0444, 32'h0, 32'h200, 5'd6, 50, '0);
    @(posedge clock);
    #2;
    check("pre_rst_dmem_req", 32'(dmem_req), 32'd1);
    check("pre_rst_stall_xm", 32'(stall_xm), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
    check("mid_rst_stall_xm", 32'(stall_xm), 32'd0);
    check("mid_rst_mw_valid", 32'(mw_valid), 32'd0);
    check("mid_rst_mem_err", 32'(mem_err), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    pending_stall = 0;
    issue(1'b1, 14'h0004, 32'h0000_5555, 32'h0, 32'h300, 5'd10, 0, '0);
    issue(1'b1, 14'h0005, 32'h0000_0010, 32'h0, 32'h301, 5'd11, 4, 32'hA5A5_0001);
    bubbles(4);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
